dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the memory stage (port M: loads/stores) and the
//  fetch unit (port F: instruction reads). Sits between the pipeline and the dmem interface.
//  Fixed priority to M with anti-starvation for F; variable-latency reads via mem_rd_ready.
//  Read timeout detection; flush discards an in-flight F read.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  STARVE_MAX  4   consecutive M grants while F waits before F is forced to win
//  TIMEOUT     64  max RD_WAIT cycles before bus error (>=2)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  m_req          in   1       M request, held until m_gnt seen
//  m_we           in   1       1=store, 0=load (valid with m_req)
//  m_addr         in   ADDR_W  M address
//  m_wdata        in   DATA_W  store data
//  m_gnt          out  1       1-cycle accept pulse
//  m_rvalid       out  1       1-cycle load data valid pulse
//  m_rdata        out  DATA_W  load data (valid with m_rvalid)
//  f_req          in   1       F read request, held until f_gnt seen
//  f_addr         in   ADDR_W  F address
//  f_gnt          out  1       1-cycle accept pulse
//  f_rvalid       out  1       1-cycle read data valid pulse
//  f_rdata        out  DATA_W  read data
//  flush          in   1       discard F response in flight / pending
//  mem_addr       out  ADDR_W  dmem address
//  mem_wr_data    out  DATA_W  dmem write data
//  mem_wr_enable  out  1       dmem write strobe (1 cycle per store)
//  mem_rd_enable  out  1       dmem read request, held until mem_rd_ready
//  mem_rd_data    in   DATA_W  dmem read data (valid with mem_rd_ready)
//  mem_rd_ready   in   1       dmem read complete
//  bus_err        out  1       1-cycle pulse on read timeout
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state=IDLE, starve_cnt=0, owner=M, drop=0.
//  - States: IDLE, RD_WAIT.
//  - Eligible req = x_req & ~x_gnt (a requester is masked the cycle its gnt is high).
//  - IDLE arbitration: only M eligible -> M; only F -> F; both -> F if starve_cnt==STARVE_MAX,
//    else M. starve_cnt: +1 (sat) on M win while F eligible; cleared on F win.
//  - Win, write (M & m_we): next cycle mem_addr/mem_wr_data latched, mem_wr_enable=1 for exactly
//    1 cycle, m_gnt=1; stay IDLE (next arbitration same cycle as write strobe allowed).
//  - Win, read: next cycle mem_addr latched, mem_rd_enable=1, x_gnt=1, owner latched,
//    wait_cnt=0, -> RD_WAIT. Read latency to x_rvalid = 1 cycle after mem_rd_ready sampled.
//  - RD_WAIT: mem_rd_enable held 1, addr stable, no new grants. On mem_rd_ready: drop
//    mem_rd_enable, x_rdata<=mem_rd_data, x_rvalid=1 (unless owner=F & drop), -> IDLE.
//  - Timeout: wait_cnt reaches TIMEOUT-1 w/o ready -> bus_err=1, x_rvalid=1, x_rdata=0,
//    mem_rd_enable=0, -> IDLE. Late mem_rd_ready after timeout ignored.
//  - flush: pending f_req not granted that cycle; if owner=F in RD_WAIT set drop=1 (response
//    suppressed, port still waits for ready/timeout). drop cleared on leaving RD_WAIT.
//    flush never affects M transactions. flush & mem_rd_ready same cycle -> F response dropped.
//  - reset mid-RD_WAIT: abort immediately, no rvalid, mem_rd_enable=0 next cycle.
//  - Simultaneous m_req and f_req in RD_WAIT: both wait; arbitrated on return to IDLE.
// TESTING
//  - Load M addr 0x100, ready after 3 cycles data 0xDEADBEEF -> m_gnt 1 pulse, mem_rd_enable
//    high 3 cycles, m_rvalid with m_rdata=0xDEADBEEF 1 cycle after ready.
//  - Store M addr 0x40 data 0x12345678 -> mem_wr_enable exactly 1 cycle, addr/data match,
//    m_gnt pulse, no m_rvalid.
//  - M and F continuously requesting (STARVE_MAX=4, 0-latency reads) -> grant order
//    M,M,M,M,F,M,M,M,M,F...
//  - F read in flight, flush asserted, ready w/ 0xCAFE0000 -> f_rvalid never asserted; next
//    M request granted the cycle after return to IDLE.
//  - mem_rd_ready never asserted (TIMEOUT=64) -> bus_err pulse 64 cycles after grant,
//    rvalid with rdata=0, port returns to IDLE.
//  - reset asserted during RD_WAIT -> all outputs 0 next cycle, no rvalid, fresh arbitration.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the pipeline ports (M, F), the dmem port and the arbiter.
// The arbiter connects through the slave modport.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_enable;
  logic              mem_rd_enable;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_ready;
  logic              bus_err;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    input  f_req, f_addr, flush,
    input  mem_rd_data, mem_rd_ready,
    output m_gnt, m_rvalid, m_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output mem_addr, mem_wr_data,
    output mem_wr_enable, mem_rd_enable,
    output bus_err
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    output f_req, f_addr, flush,
    output mem_rd_data, mem_rd_ready,
    input  m_gnt, m_rvalid, m_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  mem_addr, mem_wr_data,
    input  mem_wr_enable, mem_rd_enable,
    input  bus_err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the dmem port between memory stage (M) and fetch (F).
// M has priority; F is forced through after STARVE_MAX lost rounds.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [WW-1:0] W_END = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] W_ONE = WW'(1);

  typedef enum logic { IDLE, RD_WAIT } state_t;
  typedef enum logic { OWN_M, OWN_F } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              m_gnt_q, m_gnt_d;
  logic              f_gnt_q, f_gnt_d;
  logic              m_rv_q, m_rv_d;
  logic              f_rv_q, f_rv_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              err_q, err_d;

  logic              m_elig;
  logic              f_elig;
  logic              f_force;
  logic              m_win;
  logic              f_win;
  logic              drop_now;
  logic              done;
  logic [DATA_W-1:0] resp;

  // State register; reset aborts any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_M;
      drop_q    <= 1'b0;
      starve_q  <= '0;
      wait_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      m_gnt_q   <= 1'b0;
      f_gnt_q   <= 1'b0;
      m_rv_q    <= 1'b0;
      f_rv_q    <= 1'b0;
      m_rdata_q <= '0;
      f_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      drop_q    <= drop_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      m_gnt_q   <= m_gnt_d;
      f_gnt_q   <= f_gnt_d;
      m_rv_q    <= m_rv_d;
      f_rv_q    <= f_rv_d;
      m_rdata_q <= m_rdata_d;
      f_rdata_q <= f_rdata_d;
      err_q     <= err_d;
    end
  end

  // Arbitration, read tracking and response routing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    starve_d  = starve_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = re_q;
    m_gnt_d   = 1'b0;
    f_gnt_d   = 1'b0;
    m_rv_d    = 1'b0;
    f_rv_d    = 1'b0;
    m_rdata_d = m_rdata_q;
    f_rdata_d = f_rdata_q;
    err_d     = 1'b0;

    // A requester still sees its own gnt this cycle: mask it.
    m_elig  = bus.m_req & ~m_gnt_q;
    f_elig  = bus.f_req & ~f_gnt_q & ~bus.flush;
    f_force = f_elig & (starve_q == S_MAX);
    m_win   = m_elig & ~f_force;
    f_win   = f_elig & ~m_win;

    drop_now = drop_q |
               (bus.flush & (owner_q == OWN_F));
    done     = 1'b0;
    resp     = '0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          m_win: begin
            m_gnt_d = 1'b1;
            addr_d  = bus.m_addr;
            if (f_elig && starve_q != S_MAX)
              starve_d = starve_q + S_ONE;
            if (bus.m_we) begin
              wdata_d = bus.m_wdata;
              we_d    = 1'b1;
            end else begin
              re_d    = 1'b1;
              owner_d = OWN_M;
              wait_d  = '0;
              state_d = RD_WAIT;
            end
          end
          f_win: begin
            f_gnt_d  = 1'b1;
            addr_d   = bus.f_addr;
            starve_d = '0;
            re_d     = 1'b1;
            owner_d  = OWN_F;
            wait_d   = '0;
            state_d  = RD_WAIT;
          end
          default: ;
        endcase
      end
      RD_WAIT: begin
        if (bus.mem_rd_ready) begin
          done = 1'b1;
          resp = bus.mem_rd_data;
        end else if (wait_q == W_END) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + W_ONE;
          drop_d = drop_now;
        end
        if (done) begin
          re_d    = 1'b0;
          drop_d  = 1'b0;
          state_d = IDLE;
          if (owner_q == OWN_M) begin
            m_rv_d    = 1'b1;
            m_rdata_d = resp;
          end else if (!drop_now) begin
            f_rv_d    = 1'b1;
            f_rdata_d = resp;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.m_gnt         = m_gnt_q;
  assign bus.m_rvalid      = m_rv_q;
  assign bus.m_rdata       = m_rdata_q;
  assign bus.f_gnt         = f_gnt_q;
  assign bus.f_rvalid      = f_rv_q;
  assign bus.f_rdata       = f_rdata_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wr_data   = wdata_q;
  assign bus.mem_wr_enable = we_q;
  assign bus.mem_rd_enable = re_q;
  assign bus.bus_err       = err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: cycle table
// plus starvation, timeout and reset-abort sequences.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic auto_rdy;
  logic rdy;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  assign bus.mem_rd_ready = auto_rdy ? bus.mem_rd_enable : rdy;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        freq;
    logic [31:0] faddr;
    logic        fl;
    logic [31:0] rd;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic        mg;
    logic        mrv;
    logic [31:0] mrd;
    logic        fg;
    logic        frv;
    logic [31:0] frd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t cur();
    out_t o;
    o.mg   = bus.m_gnt;
    o.mrv  = bus.m_rvalid;
    o.mrd  = bus.m_rdata;
    o.fg   = bus.f_gnt;
    o.frv  = bus.f_rvalid;
    o.frd  = bus.f_rdata;
    o.addr = bus.mem_addr;
    o.wd   = bus.mem_wr_data;
    o.we   = bus.mem_wr_enable;
    o.re   = bus.mem_rd_enable;
    o.err  = bus.bus_err;
    return o;
  endfunction

  task automatic apply(in_t i);
    reset       = i.rst;
    bus.m_req   = i.mreq;
    bus.m_we    = i.mwe;
    bus.m_addr  = i.maddr;
    bus.m_wdata = i.mwd;
    bus.f_req   = i.freq;
    bus.f_addr  = i.faddr;
    bus.flush   = i.fl;
    bus.mem_rd_data = i.rd;
    rdy         = i.rdy;
  endtask

  task automatic chk_o(string nm, out_t g, out_t e);
    n_tot++;
    if (g === e) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, g, e);
  endtask

  task automatic chk(string nm, logic [31:0] g,
                     logic [31:0] e);
    n_tot++;
    if (g === e) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, g, e);
  endtask

  task automatic add(in_t i, out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vq.push_back(v);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] WD = 32'h12345678;
  localparam logic [31:0] BD = 32'h0BADF00D;
  localparam logic [31:0] AA = 32'h55AA55AA;

  in_t  z;
  out_t e;
  in_t  t;
  int   k;
  int   gq[$];

  initial begin
    z = '0;
    auto_rdy = 1'b0;
    apply(z);
    reset = 1'b1;

    // {rst,mreq,mwe,maddr,mwd,freq,faddr,fl,rd,rdy}
    // {mg,mrv,mrd,fg,frv,frd,addr,wd,we,re,err}
    add('{1,0,0,0,0,0,0,0,0,0},
        '{0,0,0,0,0,0,0,0,0,0,0});
    add(z, '{0,0,0,0,0,0,0,0,0,0,0});
    add('{0,1,0,'h100,0,0,0,0,0,0},
        '{1,0,0,0,0,0,'h100,0,0,1,0});
    add('{0,1,0,'h100,0,0,0,0,0,0},
        '{0,0,0,0,0,0,'h100,0,0,1,0});
    add(z, '{0,0,0,0,0,0,'h100,0,0,1,0});
    add('{0,0,0,0,0,0,0,0,DB,1},
        '{0,1,DB,0,0,0,'h100,0,0,0,0});
    add(z, '{0,0,DB,0,0,0,'h100,0,0,0,0});
    add('{0,1,1,'h40,WD,0,0,0,0,0},
        '{1,0,DB,0,0,0,'h40,WD,1,0,0});
    add('{0,1,1,'h40,WD,0,0,0,0,0},
        '{0,0,DB,0,0,0,'h40,WD,0,0,0});
    add(z, '{0,0,DB,0,0,0,'h40,WD,0,0,0});
    add('{0,0,0,0,0,1,'h200,0,0,0},
        '{0,0,DB,1,0,0,'h200,WD,0,1,0});
    add('{0,0,0,0,0,1,'h200,1,0,0},
        '{0,0,DB,0,0,0,'h200,WD,0,1,0});
    add('{0,1,0,'h300,0,0,0,0,'hCAFE0000,1},
        '{0,0,DB,0,0,0,'h200,WD,0,0,0});
    add('{0,1,0,'h300,0,0,0,0,0,0},
        '{1,0,DB,0,0,0,'h300,WD,0,1,0});
    add('{0,0,0,0,0,0,0,0,BD,1},
        '{0,1,BD,0,0,0,'h300,WD,0,0,0});
    add('{0,0,0,0,0,1,'h204,0,0,0},
        '{0,0,BD,1,0,0,'h204,WD,0,1,0});
    add('{0,0,0,0,0,0,0,1,'h11112222,1},
        '{0,0,BD,0,0,0,'h204,WD,0,0,0});
    add('{0,0,0,0,0,1,'h208,0,0,0},
        '{0,0,BD,1,0,0,'h208,WD,0,1,0});
    add('{0,0,0,0,0,0,0,0,AA,1},
        '{0,0,BD,0,1,AA,'h208,WD,0,0,0});
    add('{0,0,0,0,0,1,'h20C,1,0,0},
        '{0,0,BD,0,0,AA,'h208,WD,0,0,0});
    add('{0,0,0,0,0,1,'h20C,0,0,0},
        '{0,0,BD,1,0,AA,'h20C,WD,0,1,0});
    add('{0,0,0,0,0,0,0,0,'h77,1},
        '{0,0,BD,0,1,'h77,'h20C,WD,0,0,0});
    add('{0,1,0,'h310,0,0,0,0,0,0},
        '{1,0,BD,0,0,'h77,'h310,WD,0,1,0});
    add('{0,0,0,0,0,0,0,1,'h99,1},
        '{0,1,'h99,0,0,'h77,'h310,WD,0,0,0});

    foreach (vq[n]) begin
      apply(vq[n].i);
      tick();
      chk_o($sformatf("vec%0d", n), cur(), vq[n].o);
    end

    // Starvation: both ports request forever,
    // zero-latency memory.
    apply(z);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    auto_rdy = 1'b1;
    bus.m_req = 1'b1;
    bus.f_req = 1'b1;
    for (int c = 0; c < 200 && gq.size() < 10; c++) begin
      tick();
      if (bus.m_gnt && bus.f_gnt)
        chk("dual_gnt", 1, 0);
      if (bus.m_gnt) gq.push_back(0);
      if (bus.f_gnt) gq.push_back(1);
    end
    chk("starve_cnt", gq.size(), 10);
    foreach (gq[n])
      chk($sformatf("starve_g%0d", n), gq[n],
          (n % 5 == 4) ? 1 : 0);

    // Timeout: memory never answers.
    apply(z);
    auto_rdy = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h400;
    tick();
    chk("to_gnt", bus.m_gnt, 1);
    bus.m_req = 1'b0;
    k = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      k++;
      if (bus.bus_err) break;
    end
    chk("to_cycles", k, 64);
    chk("to_err", bus.bus_err, 1);
    chk("to_rvalid", bus.m_rvalid, 1);
    chk("to_rdata", bus.m_rdata, 0);
    chk("to_rden", bus.mem_rd_enable, 0);
    rdy = 1'b1;
    bus.mem_rd_data = 32'hFFFF0000;
    tick();
    chk("to_late", {bus.m_rvalid, bus.bus_err}, 0);
    rdy = 1'b0;
    bus.m_req  = 1'b1;
    bus.m_we   = 1'b1;
    bus.m_addr = 32'h44;
    tick();
    chk("to_idle_gnt", bus.m_gnt, 1);
    chk("to_idle_we", bus.mem_wr_enable, 1);

    // Reset while an F read is outstanding.
    apply(z);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h500;
    tick();
    chk("rst_fgnt", bus.f_gnt, 1);
    bus.f_req = 1'b0;
    tick();
    chk("rst_wait", bus.mem_rd_enable, 1);
    reset = 1'b1;
    rdy   = 1'b1;
    bus.mem_rd_data = 32'hAA;
    tick();
    e = '0;
    chk_o("rst_abort", cur(), e);
    reset = 1'b0;
    rdy   = 1'b0;
    tick();
    chk_o("rst_quiet", cur(), e);
    t = z;
    t.freq  = 1'b1;
    t.faddr = 32'h600;
    t.mreq  = 1'b1;
    t.maddr = 32'h700;
    apply(t);
    tick();
    chk("rst_arb_m", bus.m_gnt, 1);
    chk("rst_arb_addr", bus.mem_addr, 32'h700);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
